// File: rtl/mlp_stream_pkg.sv
// rtl/mlp_stream_pkg.sv - shared state type and default sizing for the MLP stream driver
package mlp_stream_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    OUT    = 2'd2
  } state_e;

  localparam int WIDTH_A_DEF       = 4;
  localparam int NUM_A_DEF         = 11;
  localparam int OUTWIDTH_DEF      = 3;
  localparam int SETTLE_CYCLES_DEF = 2;
  localparam int CLS_OFFSET_DEF    = 3;

  // Counter/index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/feature_slot_reg.sv
// rtl/feature_slot_reg.sv - NUM_A x WIDTH_A feature register file exposed as the packed classifier input
module feature_slot_reg #(
  parameter int WIDTH_A = 4,
  parameter int NUM_A   = 11,
  parameter int IDX_W   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [IDX_W-1:0]         idx_i,
  input  logic [WIDTH_A-1:0]       data_i,
  output logic [NUM_A*WIDTH_A-1:0] inp_o
);

  logic [NUM_A-1:0][WIDTH_A-1:0] slot_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q <= '0;
    end else if (we_i) begin
      slot_q[idx_i] <= data_i;
    end
  end

  assign inp_o = slot_q;

endmodule

// File: rtl/mlp_stream_driver.sv
// rtl/mlp_stream_driver.sv - collects a feature frame, holds it for the classifier to settle, returns the class
module mlp_stream_driver
  import mlp_stream_pkg::*;
#(
  parameter int WIDTH_A       = WIDTH_A_DEF,
  parameter int NUM_A         = NUM_A_DEF,
  parameter int OUTWIDTH      = OUTWIDTH_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int CLS_OFFSET    = CLS_OFFSET_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH_A-1:0]       s_data,
  input  logic                     s_last,
  output logic [NUM_A*WIDTH_A-1:0] inp,
  input  logic [OUTWIDTH-1:0]      cls_in,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [OUTWIDTH:0]        m_class,
  output logic                     frame_err,
  input  logic                     err_clr
);

  localparam int IDX_W = idx_w(NUM_A);
  localparam int CNT_W = idx_w(SETTLE_CYCLES + 1);
  localparam int RES_W = OUTWIDTH + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_A - 1);
  // Loading the full settle count makes m_valid rise SETTLE_CYCLES+1 edges after the last beat.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES);
  localparam logic [RES_W-1:0] OFFSET   = RES_W'(CLS_OFFSET);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               m_valid_q;
  logic [RES_W-1:0]   m_class_q;
  logic               frame_err_q;

  logic beat;
  logic last_slot;
  logic err_set;

  assign s_ready   = (state_q == LOAD) && !rst;
  assign beat      = s_valid && s_ready;
  assign last_slot = (idx_q == LAST_IDX);
  assign err_set   = beat && (last_slot ? !s_last : s_last);

  feature_slot_reg #(
    .WIDTH_A(WIDTH_A),
    .NUM_A  (NUM_A),
    .IDX_W  (IDX_W)
  ) u_slots (
    .clk_i (clk),
    .rst_i (rst),
    .we_i  (beat),
    .idx_i (idx_q),
    .data_i(s_data),
    .inp_o (inp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      cnt_q       <= '0;
      m_valid_q   <= 1'b0;
      m_class_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      if (err_set) begin
        frame_err_q <= 1'b1;
      end else if (err_clr) begin
        frame_err_q <= 1'b0;
      end

      case (state_q)
        LOAD: begin
          if (beat) begin
            if (last_slot) begin
              state_q <= SETTLE;
              cnt_q   <= CNT_INIT;
              idx_q   <= '0;
            end else if (s_last) begin
              idx_q <= '0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            m_class_q <= {1'b0, cls_in} + OFFSET;
            m_valid_q <= 1'b1;
            state_q   <= OUT;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign m_valid   = m_valid_q;
  assign m_class   = m_class_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mlp_stream_driver.sv
// tb/tb_mlp_stream_driver.sv - randomized self-checking bench for mlp_stream_driver
module tb_mlp_stream_driver;

  localparam int WA   = 4;
  localparam int NA   = 11;
  localparam int OW   = 3;
  localparam int SC   = 2;
  localparam int OFF  = 3;
  localparam int OFF2 = 12;
  localparam int RW   = OW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          s_valid = 1'b0;
  logic          s_last  = 1'b0;
  logic [WA-1:0] s_data  = '0;
  logic          m_ready = 1'b0;
  logic          err_clr = 1'b0;

  logic             s_ready, s_ready2, m_valid, m_valid2, frame_err, frame_err2;
  logic [NA*WA-1:0] inp, inp2;
  logic [OW-1:0]    cls_in, cls_in2;
  logic [RW-1:0]    m_class, m_class2;

  bit            cls_mode  = 1'b0;
  logic [OW-1:0] cls_const = '0;

  // Classifier stub: a constant, or a checksum of the features.
  function automatic logic [OW-1:0] cls_fn(input logic [NA*WA-1:0] v);
    int s;
    s = 0;
    for (int i = 0; i < NA; i++) s += int'(v[i*WA +: WA]);
    return OW'((s * 3 + 1) % (1 << OW));
  endfunction

  assign cls_in  = cls_mode ? cls_fn(inp)  : cls_const;
  assign cls_in2 = cls_mode ? cls_fn(inp2) : cls_const;

  mlp_stream_driver dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .inp(inp), .cls_in(cls_in), .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class),
    .frame_err(frame_err), .err_clr(err_clr)
  );

  mlp_stream_driver #(.CLS_OFFSET(OFF2)) dut_wrap (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data), .s_last(s_last),
    .inp(inp2), .cls_in(cls_in2), .m_valid(m_valid2), .m_ready(m_ready), .m_class(m_class2),
    .frame_err(frame_err2), .err_clr(err_clr)
  );

  int errors = 0;
  int checks = 0;

  logic [WA-1:0] exp_slot [NA];
  int            exp_idx;
  bit            exp_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NA*WA-1:0] model_inp();
    logic [NA*WA-1:0] v;
    for (int i = 0; i < NA; i++) v[i*WA +: WA] = exp_slot[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NA; i++) exp_slot[i] = '0;
    exp_idx = 0;
    exp_err = 1'b0;
  endtask

  // Offers one beat from a negedge until accepted; returns at the negedge after acceptance.
  task automatic send_beat(input logic [WA-1:0] d, input bit last, output bit got);
    bit acc;
    bit set;
    int guard;
    got   = 1'b0;
    acc   = 1'b0;
    guard = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    while (!acc) begin
      acc = s_ready;
      @(posedge clk);
      set = 1'b0;
      if (acc) begin
        exp_slot[exp_idx] = d;
        if (exp_idx == NA - 1) begin
          set = !last; exp_idx = 0; got = 1'b1;
        end else if (last) begin
          set = 1'b1; exp_idx = 0;
        end else begin
          exp_idx++;
        end
      end
      if (set) exp_err = 1'b1;
      else if (err_clr) exp_err = 1'b0;
      @(negedge clk);
      guard++;
      if (!acc && guard > 50) begin
        check("beat_accept_timeout", 0, 1);
        acc = 1'b1;
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input int n, input int last_at, input bit rnd, input bit gaps, output bit res);
    bit r;
    logic [WA-1:0] d;
    res = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          s_data = WA'($urandom_range(0, 15));
          @(negedge clk);
        end
      end
      d = rnd ? WA'($urandom_range(0, 15)) : WA'(i + 1);
      send_beat(d, i == last_at, r);
      if (r) res = 1'b1;
    end
  endtask

  task automatic expect_result();
    int lat;
    int c;
    check("s_ready_in_settle", s_ready, 0);
    lat = 0;
    while (!m_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    c = int'(cls_mode ? cls_fn(model_inp()) : cls_const);
    check("latency", lat, SC + 1);
    check("m_class", m_class, (c + OFF) % (1 << RW));
    check("m_class_off12", m_class2, (c + OFF2) % (1 << RW));
    check("m_valid_off12", m_valid2, 1);
    check("inp", inp, model_inp());
    check("inp_off12", inp2, model_inp());
    check("frame_err_at_result", frame_err, exp_err);
  endtask

  task automatic release_result(input int hold);
    logic [RW-1:0]    c0;
    logic [NA*WA-1:0] i0;
    c0 = m_class;
    i0 = inp;
    for (int k = 0; k < hold; k++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = WA'($urandom_range(0, 15));
      s_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold_m_valid", m_valid, 1);
      check("hold_m_class", m_class, c0);
      check("hold_inp", inp, i0);
      check("hold_s_ready", s_ready, 0);
    end
    s_valid = 1'b0; s_last = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("m_valid_drop", m_valid, 0);
    check("s_ready_back", s_ready, 1);
  endtask

  task automatic no_result(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("no_m_valid", m_valid, 0);
    end
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 1'b0;
    check("frame_err_cleared", frame_err, 0);
  endtask

  // Asynchronous reset asserted between edges; outputs must drop without a clock.
  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_inp", inp, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_m_class", m_class, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_release_s_ready", s_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit res;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    reset_pulse();

    // Nominal frame 1..11 with a constant class.
    cls_mode = 1'b0; cls_const = 3'd5;
    send_frame(NA, NA - 1, 1'b0, 1'b0, res);
    check("nominal_result", res, 1);
    expect_result();
    check("nominal_m_class_8", m_class, 8);
    release_result(0);

    // Random features, random gaps, long backpressure.
    cls_mode = 1'b1;
    for (int f = 0; f < 4; f++) begin
      send_frame(NA, NA - 1, 1'b1, 1'b1, res);
      expect_result();
      release_result(10);
    end

    // Early s_last discards the frame.
    send_frame(4, 3, 1'b1, 1'b0, res);
    check("short_no_result", res, 0);
    check("short_frame_err", frame_err, 1);
    no_result(6);
    send_frame(NA, NA - 1, 1'b1, 1'b1, res);
    expect_result();
    check("err_sticky", frame_err, 1);
    release_result(2);
    clear_err();

    // Missing s_last on beat 11 still yields a result.
    send_frame(NA, -1, 1'b1, 1'b0, res);
    expect_result();
    check("missing_last_err", frame_err, 1);
    release_result(1);
    clear_err();

    // Set wins over clear in the same cycle.
    send_frame(2, -1, 1'b1, 1'b0, res);
    err_clr = 1'b1;
    send_beat(WA'($urandom_range(0, 15)), 1'b1, res);
    err_clr = 1'b0;
    check("set_beats_clear", frame_err, 1);
    clear_err();

    // Offset wrap: 7 + 12 = 19 -> 3.
    cls_mode = 1'b0; cls_const = 3'd7;
    send_frame(NA, NA - 1, 1'b1, 1'b0, res);
    expect_result();
    check("wrap_m_class_3", m_class2, 3);
    release_result(0);

    // Reset while settling, then while holding a result.
    cls_mode = 1'b1;
    send_frame(NA, NA - 1, 1'b1, 1'b0, res);
    reset_pulse();
    no_result(6);
    send_frame(NA, NA - 1, 1'b1, 1'b1, res);
    expect_result();
    reset_pulse();
    no_result(4);
    send_frame(NA, NA - 1, 1'b1, 1'b0, res);
    expect_result();
    release_result(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
